qspi_rom_sequencer: RTL and testbench
=====================================

QSPI_ROM_SEQUENCER -- requirements
Module: qspi_rom_sequencer

Interface
REQ-001 Parameter: ADDR_W, 12, requester address width (cartridge byte address).
REQ-002 Parameter: BASE_ADDR, 24'h100000, flash byte offset added to every request.
REQ-003 Parameter: DUMMY_CYC, 4, dummy SCK periods after mode nibbles (2..15).
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: req0_valid / req0_addr  in  1 / ADDR_W  requester 0 (CPU fetch) byte request.
REQ-007 Port: req1_valid / req1_addr  in  1 / ADDR_W  requester 1 (aux/debug) byte request.
REQ-008 Port: ack0 / ack1  out  1 / 1  one-cycle completion strobe per requester.
REQ-009 Port: rdata  out  8  read byte, valid in the cycle ackN is high.
REQ-010 Port: busy  out  1  high whenever state is not IDLE.
REQ-011 Port: qspi_cs_n / qspi_sclk  out  1 / 1  flash select (low active), flash clock.
REQ-012 Port: qspi_io_out / qspi_io_oe / qspi_io_in  out / out / in  4 / 4 / 4  IO0..IO3 data, per-bit enable, sampled input.

Function
REQ-013 SHALL run states IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE in that order; no other transitions except reset.
REQ-014 SHALL generate SCK = clk/2: each SCK period is two clk cycles, first with sclk=0 (outputs update), second with sclk=1; qspi_io_in sampled on the clk edge ending the sclk=1 cycle.
REQ-015 IDLE: cs_n=1, sclk=0, oe=0000; on any valid, latch winner's address and id, go CMD next cycle.
REQ-016 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last (round-robin; last_grant resets to 1, so req0 wins first tie).
REQ-017 CMD: 8 SCK, opcode 0xEB MSB-first on IO0; io_out[3:2]=11, oe=1101; cs_n=0 from first CMD cycle.
REQ-018 ADDR: 6 SCK, flash address (BASE_ADDR + zero-extended addr) mod 2^24, MSB nibble first on IO[3:0], oe=1111.
REQ-019 MODE: 2 SCK, nibbles 0x0,0x0 (no continuous-read), oe=1111.
REQ-020 DUMMY: DUMMY_CYC SCK, oe=0000; DATA: 2 SCK, oe=0000, high nibble first.
REQ-021 DONE: 1 clk, cs_n=1, sclk=0, ackN=1 for granted id only, rdata = assembled byte; then IDLE.
REQ-022 Latency valid-to-ack (IDLE, no contention): 1 + 2*(18+DUMMY_CYC) + 1 clk = 46 clk at default.
REQ-023 cs_n high minimum 2 clk between transactions (DONE + IDLE).
REQ-024 Requester SHALL hold valid and addr stable until its ack; address latched at grant, later changes ignored.
REQ-025 valid deasserted after grant: transaction completes, ack still issued.
REQ-026 Requester re-asserting valid in its own ack cycle SHALL be seen in following IDLE arbitration.
REQ-027 rdata holds last value outside ack cycles.

Reset
REQ-028 rst_n low at any clk edge: state=IDLE, cs_n=1, sclk=0, io_out=0000, oe=0000, ack0=ack1=0, busy=0, rdata=0x00, last_grant=1.
REQ-029 Reset mid-transaction aborts without ack; first post-reset transaction restarts with CMD.

Structure
REQ-030 Shared package holds state enum, opcode 0xEB, CMD/ADDR/MODE/DATA SCK counts, OE encodings.
REQ-031 One sub-module: qspi_rr_arbiter (2-way round-robin grant, last_grant register).
REQ-032 Single SCK-period counter plus phase bit; no clock derived from logic (sclk is a data output).

Verification
REQ-033 Flash model with 0xA5 at 0x100123; req0 addr 0x123 -> cs_n falls next cycle, IO0 shows 1110_1011, ADDR nibbles 1,0,0,1,2,3, ack0 at clk 46, rdata=0xA5.
REQ-034 req0 and req1 valid same cycle, both held -> req0 served, then req1, then req0 again; cs_n high 2 clk between.
REQ-035 oe check each state: CMD 1101, ADDR/MODE 1111, DUMMY/DATA 0000, IDLE/DONE 0000.
REQ-036 rst_n low at clk 20 of transaction -> next edge cs_n=1, oe=0, no ack; new request completes correctly.
REQ-037 req1_addr changed after grant, valid dropped after grant -> transaction uses latched addr, ack1 still pulses once.
REQ-038 DUMMY_CYC=8 build, addr 0xFFF with BASE_ADDR 24'hFFFFFF -> flash address 0x000FFE (wrap), latency 54 clk.

Source files
------------

// File: rtl/qspi_rom_sequencer_pkg.sv
// Shared definitions for the quad-SPI ROM fetch sequencer: state encoding,
// flash opcode, per-phase SCK counts and IO output-enable patterns.
package qspi_rom_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_MODE,
      ST_DUMMY,
      ST_DATA,
      ST_DONE
   } state_t;

   // Fast Read Quad I/O opcode, shifted out single-wire on IO0.
   localparam logic [7:0] OPCODE      = 8'hEB;

   localparam logic [3:0] CMD_SCK     = 4'd8;
   localparam logic [3:0] ADDR_SCK    = 4'd6;
   localparam logic [3:0] MODE_SCK    = 4'd2;
   localparam logic [3:0] DATA_SCK    = 4'd2;

   // Mode nibble 0x0 keeps the flash out of continuous-read mode.
   localparam logic [3:0] MODE_NIBBLE = 4'h0;

   // IO1 stays released during the command so the flash may drive it.
   localparam logic [3:0] OE_CMD      = 4'b1101;
   localparam logic [3:0] OE_QUAD     = 4'b1111;
   localparam logic [3:0] OE_OFF      = 4'b0000;

   // {oe, io_out} for SCK period idx of state st.
   function automatic logic [7:0] io_drive(input state_t st, input logic [2:0] idx,
                                           input logic [23:0] faddr);
      logic [4:0] shamt;
      logic [3:0] nib;
      logic [7:0] r;
      shamt = 5'd20 - {idx, 2'b00};
      nib   = 4'(faddr >> shamt);
      case (st)
         ST_CMD:  r = {OE_CMD, 3'b110, OPCODE[3'd7 - idx]};
         ST_ADDR: r = {OE_QUAD, nib};
         ST_MODE: r = {OE_QUAD, MODE_NIBBLE};
         default: r = {OE_OFF, 4'b0000};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/qspi_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the requester not granted last wins;
// last_grant resets to 1 so requester 0 wins the first tie.
module qspi_rr_arbiter (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic gnt_valid,
   output logic gnt_id
);

   logic last_grant;

   // Grant selection from current requests and the previous winner.
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = 1'b0;
      if (req0 && req1) begin
         gnt_id = ~last_grant;
      end else if (req1) begin
         gnt_id = 1'b1;
      end
   end

   // Remember who was granted whenever the grant is actually taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (take && gnt_valid) begin
         last_grant <= gnt_id;
      end
   end

endmodule

// File: rtl/qspi_rom_sequencer.sv
// Quad-SPI ROM byte fetcher shared by two requesters. Each request runs a
// complete 0xEB transaction (CMD, ADDR, MODE, DUMMY, DATA) with SCK = clk/2.
// Valid/ready contract: a requester raises valid with a stable addr and keeps
// it until its one-cycle ack; the address is captured at grant, so later addr
// changes or an early valid drop do not affect the transaction in flight.
module qspi_rom_sequencer
   import qspi_rom_sequencer_pkg::*;
#(
   parameter int          ADDR_W    = 12,
   parameter logic [23:0] BASE_ADDR = 24'h100000,
   parameter int          DUMMY_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              ack0,
   output logic              ack1,
   output logic [7:0]        rdata,
   output logic              busy,
   output logic              qspi_cs_n,
   output logic              qspi_sclk,
   output logic [3:0]        qspi_io_out,
   output logic [3:0]        qspi_io_oe,
   input  logic [3:0]        qspi_io_in
);

   state_t            state;
   state_t            next_st;
   logic [3:0]        cnt;       // SCK period index within the current state
   logic              phase;     // 0: sclk low half, 1: sclk high half
   logic              id;
   logic [23:0]       faddr;
   logic [3:0]        data_hi;
   logic [3:0]        last_cnt;
   logic              gnt_valid;
   logic              gnt_id;
   logic [ADDR_W-1:0] gnt_addr;
   logic [23:0]       req_faddr;

   qspi_rr_arbiter u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0_valid),
      .req1      (req1_valid),
      .take      (state == ST_IDLE),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign gnt_addr  = gnt_id ? req1_addr : req0_addr;
   assign req_faddr = BASE_ADDR + 24'(gnt_addr);
   assign busy      = (state != ST_IDLE);

   // Length of each shifting state and the state that follows it.
   always_comb begin
      last_cnt = 4'd0;
      next_st  = ST_IDLE;
      case (state)
         ST_CMD:   begin last_cnt = CMD_SCK - 4'd1;       next_st = ST_ADDR;  end
         ST_ADDR:  begin last_cnt = ADDR_SCK - 4'd1;      next_st = ST_MODE;  end
         ST_MODE:  begin last_cnt = MODE_SCK - 4'd1;      next_st = ST_DUMMY; end
         ST_DUMMY: begin last_cnt = 4'(DUMMY_CYC - 1);    next_st = ST_DATA;  end
         ST_DATA:  begin last_cnt = DATA_SCK - 4'd1;      next_st = ST_DONE;  end
         default:  begin last_cnt = 4'd0;                 next_st = ST_IDLE;  end
      endcase
   end

   // Transaction FSM; all pin outputs are registered and change only at the
   // start of an sclk-low half, so the flash sees them stable at SCK rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= 4'd0;
         phase       <= 1'b0;
         id          <= 1'b0;
         faddr       <= 24'h0;
         data_hi     <= 4'h0;
         qspi_cs_n   <= 1'b1;
         qspi_sclk   <= 1'b0;
         qspi_io_out <= 4'h0;
         qspi_io_oe  <= OE_OFF;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata       <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  state                     <= ST_CMD;
                  id                        <= gnt_id;
                  faddr                     <= req_faddr;
                  cnt                       <= 4'd0;
                  phase                     <= 1'b0;
                  qspi_cs_n                 <= 1'b0;
                  qspi_sclk                 <= 1'b0;
                  {qspi_io_oe, qspi_io_out} <= io_drive(ST_CMD, 3'd0, req_faddr);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
            end
            default: begin
               if (!phase) begin
                  phase     <= 1'b1;
                  qspi_sclk <= 1'b1;
               end else begin
                  phase     <= 1'b0;
                  qspi_sclk <= 1'b0;
                  if (state == ST_DATA && cnt == 4'd0) begin
                     data_hi <= qspi_io_in;
                  end
                  if (cnt == last_cnt) begin
                     cnt   <= 4'd0;
                     state <= next_st;
                     if (next_st == ST_DONE) begin
                        qspi_cs_n   <= 1'b1;
                        qspi_io_out <= 4'h0;
                        qspi_io_oe  <= OE_OFF;
                        rdata       <= {data_hi, qspi_io_in};
                        ack0        <= ~id;
                        ack1        <= id;
                     end else begin
                        {qspi_io_oe, qspi_io_out} <= io_drive(next_st, 3'd0, faddr);
                     end
                  end else begin
                     cnt                       <= cnt + 4'd1;
                     {qspi_io_oe, qspi_io_out} <= io_drive(state, 3'(cnt + 4'd1), faddr);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_rom_sequencer.sv
// Bench for qspi_rom_sequencer: two builds (default, and DUMMY_CYC=8 with a
// wrapping base), each with a behavioural quad-SPI flash on its pins.
module tb_qspi_rom_sequencer;

   localparam int NENV = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NENV-1:0] rst_n, r0v, r1v;
   logic [11:0]     r0a [NENV];
   logic [11:0]     r1a [NENV];
   logic [NENV-1:0] ack0_v, ack1_v, busy_v, cs_n_v, sclk_v;
   logic [7:0]      rdata_a  [NENV];
   logic [3:0]      io_out_a [NENV];
   logic [3:0]      io_oe_a  [NENV];

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q    [$];
   logic       exp_id_q [$];

   function automatic int dummy_of(input int e);
      return (e == 0) ? 4 : 8;
   endfunction

   function automatic logic [23:0] base_of(input int e);
      return (e == 0) ? 24'h100000 : 24'hFFFFFF;
   endfunction

   // Flash byte address seen by the device: base plus offset, modulo 2^24.
   function automatic logic [23:0] flash_addr(input int e, input logic [11:0] a);
      longint s;
      s = longint'(base_of(e)) + longint'(a);
      return 24'(s % 64'h0100_0000);
   endfunction

   // Flash contents.
   function automatic logic [7:0] mem_byte(input logic [23:0] fa);
      if (fa == 24'h100123) return 8'hA5;
      return fa[7:0] ^ {fa[11:8], fa[15:12]} ^ fa[23:16] ^ 8'h3C;
   endfunction

   for (genvar g = 0; g < NENV; g++) begin : g_env
      localparam int          DC = (g == 0) ? 4 : 8;
      localparam logic [23:0] BA = (g == 0) ? 24'h100000 : 24'hFFFFFF;
      logic [3:0]  io_in     = 4'h0;
      int          sck_n     = 0;
      int          last_nsck = 0;
      int          proto_err = 0;
      int          idle_err  = 0;
      logic [7:0]  cmd_sh = 8'h0, cmd_last = 8'h0, mode_sh = 8'h0, mode_last = 8'h0;
      logic [23:0] fa_sh = 24'h0, fa_last = 24'h0;
      logic [7:0]  byte_out;

      qspi_rom_sequencer #(.ADDR_W(12), .BASE_ADDR(BA), .DUMMY_CYC(DC)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n[g]),
         .req0_valid  (r0v[g]),
         .req0_addr   (r0a[g]),
         .req1_valid  (r1v[g]),
         .req1_addr   (r1a[g]),
         .ack0        (ack0_v[g]),
         .ack1        (ack1_v[g]),
         .rdata       (rdata_a[g]),
         .busy        (busy_v[g]),
         .qspi_cs_n   (cs_n_v[g]),
         .qspi_sclk   (sclk_v[g]),
         .qspi_io_out (io_out_a[g]),
         .qspi_io_oe  (io_oe_a[g]),
         .qspi_io_in  (io_in)
      );

      // Flash: decode the frame on SCK rises, drive read data for DATA periods.
      always @(posedge sclk_v[g] or posedge cs_n_v[g]) begin
         if (cs_n_v[g]) begin
            last_nsck = sck_n;
            cmd_last  = cmd_sh;
            fa_last   = fa_sh;
            mode_last = mode_sh;
            sck_n     = 0;
         end else begin
            if (sck_n < 8) begin
               if (io_oe_a[g] !== 4'b1101 || io_out_a[g][3:2] !== 2'b11) proto_err++;
               cmd_sh = {cmd_sh[6:0], io_out_a[g][0]};
            end else if (sck_n < 14) begin
               if (io_oe_a[g] !== 4'b1111) proto_err++;
               fa_sh = {fa_sh[19:0], io_out_a[g]};
            end else if (sck_n < 16) begin
               if (io_oe_a[g] !== 4'b1111) proto_err++;
               mode_sh = {mode_sh[3:0], io_out_a[g]};
            end else if (io_oe_a[g] !== 4'b0000) begin
               proto_err++;
            end
            byte_out = mem_byte(fa_sh);
            if (sck_n == 16 + DC)      io_in = byte_out[7:4];
            else if (sck_n == 17 + DC) io_in = byte_out[3:0];
            else                       io_in = 4'($urandom);
            sck_n++;
         end
      end

      // Deselected bus must be quiet; acks are exclusive and only with cs_n high.
      always @(negedge clk) begin
         if (cs_n_v[g] === 1'b1 && (sclk_v[g] !== 1'b0 || io_oe_a[g] !== 4'b0000)) idle_err++;
         if (ack0_v[g] === 1'b1 && ack1_v[g] === 1'b1) idle_err++;
         if ((ack0_v[g] | ack1_v[g]) === 1'b1 && cs_n_v[g] !== 1'b1) idle_err++;
      end
   end

   // Waits for an ack on env e; cyc = negedges waited, -1 on timeout.
   task automatic wait_ack(input int e, input int limit, output int cyc,
                           output logic [1:0] acks, output logic [7:0] d);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      acks = 2'b00;
      d    = 8'h00;
      while (!seen && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (ack0_v[e] === 1'b1 || ack1_v[e] === 1'b1) begin
            seen = 1'b1;
            acks = {ack1_v[e], ack0_v[e]};
            d    = rdata_a[e];
         end
      end
      if (!seen) cyc = -1;
   endtask

   task automatic do_reset();
      rst_n = '0;
      r0v   = '0;
      r1v   = '0;
      for (int e = 0; e < NENV; e++) begin
         r0a[e] = 12'h0;
         r1a[e] = 12'h0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cs_n_v[0] !== 1'b1)     begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n_v[0]); end
      checks++; if (sclk_v[0] !== 1'b0)     begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk_v[0]); end
      checks++; if (io_oe_a[0] !== 4'h0)    begin failures++; $display("FAIL reset_oe got=%b exp=0000", io_oe_a[0]); end
      checks++; if (io_out_a[0] !== 4'h0)   begin failures++; $display("FAIL reset_io_out got=%b exp=0000", io_out_a[0]); end
      checks++; if ({ack1_v[0], ack0_v[0]} !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", {ack1_v[0], ack0_v[0]}); end
      checks++; if (busy_v !== 2'b00)       begin failures++; $display("FAIL reset_busy got=%b exp=00", busy_v); end
      checks++; if (rdata_a[0] !== 8'h00)   begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata_a[0]); end
      rst_n = '1;
      @(negedge clk);
   endtask

   task automatic test_single_fetch();
      int cyc; logic [1:0] acks; logic [7:0] d;
      r0a[0] = 12'h123;
      r0v[0] = 1'b1;
      @(negedge clk);
      checks++; if (cs_n_v[0] !== 1'b0) begin failures++; $display("FAIL single_cs_fall got=%b exp=0", cs_n_v[0]); end
      wait_ack(0, 100, cyc, acks, d);
      r0v[0] = 1'b0;
      // Ack lands in the 46th cycle counting the cycle valid was presented.
      checks++; if (cyc + 1 !== 2 * (18 + dummy_of(0)) + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", cyc + 1, 2 * (18 + dummy_of(0)) + 1); end
      checks++; if (acks !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", acks); end
      checks++; if (d !== 8'hA5)    begin failures++; $display("FAIL single_rdata got=%h exp=a5", d); end
      checks++; if (g_env[0].cmd_last !== 8'hEB) begin failures++; $display("FAIL single_cmd got=%h exp=eb", g_env[0].cmd_last); end
      checks++; if (g_env[0].fa_last !== 24'h100123) begin failures++; $display("FAIL single_addr got=%h exp=100123", g_env[0].fa_last); end
      checks++; if (g_env[0].mode_last !== 8'h00) begin failures++; $display("FAIL single_mode got=%h exp=00", g_env[0].mode_last); end
      checks++; if (g_env[0].last_nsck !== 18 + dummy_of(0)) begin failures++; $display("FAIL single_sck_count got=%0d exp=%0d", g_env[0].last_nsck, 18 + dummy_of(0)); end
      @(negedge clk);
      checks++; if (rdata_a[0] !== 8'hA5 || ack0_v[0] !== 1'b0) begin failures++; $display("FAIL single_hold got=%h/%b exp=a5/0", rdata_a[0], ack0_v[0]); end
   endtask

   task automatic test_random_fetch();
      int cyc; logic [1:0] acks; logic [7:0] d; logic [11:0] a; logic id;
      for (int k = 0; k < 6; k++) begin
         id = 1'($urandom_range(0, 1));
         a  = 12'($urandom_range(0, 4095));
         exp_q.push_back(mem_byte(flash_addr(0, a)));
         if (id) begin r1a[0] = a; r1v[0] = 1'b1; end
         else    begin r0a[0] = a; r0v[0] = 1'b1; end
         wait_ack(0, 100, cyc, acks, d);
         r0v[0] = 1'b0;
         r1v[0] = 1'b0;
         checks++; if (cyc !== 2 * (18 + dummy_of(0)) + 1) begin failures++; $display("FAIL rand_latency k=%0d got=%0d exp=%0d", k, cyc, 2 * (18 + dummy_of(0)) + 1); end
         checks++; if (acks !== (id ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rand_ack k=%0d got=%b exp=%b", k, acks, id ? 2'b10 : 2'b01); end
         checks++; if (d !== exp_q[0]) begin failures++; $display("FAIL rand_rdata k=%0d got=%h exp=%h", k, d, exp_q[0]); end
         checks++; if (g_env[0].fa_last !== flash_addr(0, a)) begin failures++; $display("FAIL rand_addr k=%0d got=%h exp=%h", k, g_env[0].fa_last, flash_addr(0, a)); end
         @(negedge clk);
         checks++; if (rdata_a[0] !== exp_q[0] || (ack0_v[0] | ack1_v[0]) !== 1'b0) begin failures++; $display("FAIL rand_hold k=%0d got=%h exp=%h", k, rdata_a[0], exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      int cyc; logic [1:0] acks; logic [7:0] d; logic last; logic w; logic exp_id; logic [7:0] exp_d;
      do_reset();
      rst_n = '1;
      @(negedge clk);
      r0a[0] = 12'($urandom_range(0, 4095));
      r1a[0] = 12'($urandom_range(0, 4095));
      last = 1'b1;
      for (int t = 0; t < 3; t++) begin
         w = ~last;
         last = w;
         exp_id_q.push_back(w);
         exp_q.push_back(mem_byte(flash_addr(0, w ? r1a[0] : r0a[0])));
      end
      r0v[0] = 1'b1;
      r1v[0] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_ack(0, 100, cyc, acks, d);
         exp_id = exp_id_q.pop_front();
         exp_d  = exp_q.pop_front();
         checks++; if (acks !== (exp_id ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_order t=%0d got=%b exp=%b", t, acks, exp_id ? 2'b10 : 2'b01); end
         checks++; if (d !== exp_d) begin failures++; $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, d, exp_d); end
         checks++; if (cyc !== 2 * (18 + dummy_of(0)) + 1) begin failures++; $display("FAIL b2b_latency t=%0d got=%0d exp=%0d", t, cyc, 2 * (18 + dummy_of(0)) + 1); end
         if (t == 2) begin
            r0v[0] = 1'b0;
            r1v[0] = 1'b0;
         end else begin
            @(negedge clk);
            checks++; if (cs_n_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin failures++; $display("FAIL b2b_gap t=%0d got cs_n=%b busy=%b exp cs_n=1 busy=0", t, cs_n_v[0], busy_v[0]); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_late_change();
      int cyc; int extra; logic [1:0] acks; logic [7:0] d; logic [11:0] a;
      a = 12'($urandom_range(0, 4095));
      r1a[0] = a;
      r1v[0] = 1'b1;
      @(negedge clk);
      r1a[0] = a ^ 12'h5A5;
      r1v[0] = 1'b0;
      wait_ack(0, 100, cyc, acks, d);
      checks++; if (acks !== 2'b10) begin failures++; $display("FAIL late_ack got=%b exp=10", acks); end
      checks++; if (d !== mem_byte(flash_addr(0, a))) begin failures++; $display("FAIL late_rdata got=%h exp=%h", d, mem_byte(flash_addr(0, a))); end
      checks++; if (g_env[0].fa_last !== flash_addr(0, a)) begin failures++; $display("FAIL late_addr got=%h exp=%h", g_env[0].fa_last, flash_addr(0, a)); end
      extra = 0;
      repeat (60) begin
         @(negedge clk);
         if (ack0_v[0] === 1'b1 || ack1_v[0] === 1'b1) extra++;
      end
      checks++; if (extra !== 0) begin failures++; $display("FAIL late_single_ack got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid();
      int cyc; int seen; logic [1:0] acks; logic [7:0] d; logic [11:0] b;
      r0a[0] = 12'($urandom_range(0, 4095));
      r0v[0] = 1'b1;
      repeat (20) @(negedge clk);
      rst_n[0] = 1'b0;
      r0v[0]   = 1'b0;
      @(negedge clk);
      checks++; if (cs_n_v[0] !== 1'b1 || io_oe_a[0] !== 4'h0) begin failures++; $display("FAIL midrst_bus got cs_n=%b oe=%b exp cs_n=1 oe=0000", cs_n_v[0], io_oe_a[0]); end
      checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_v[0]); end
      rst_n[0] = 1'b1;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (ack0_v[0] === 1'b1 || ack1_v[0] === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_ack got=%0d exp=0", seen); end
      b = 12'($urandom_range(0, 4095));
      r1a[0] = b;
      r1v[0] = 1'b1;
      wait_ack(0, 100, cyc, acks, d);
      r1v[0] = 1'b0;
      checks++; if (cyc !== 2 * (18 + dummy_of(0)) + 1) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", cyc, 2 * (18 + dummy_of(0)) + 1); end
      checks++; if (acks !== 2'b10 || d !== mem_byte(flash_addr(0, b))) begin failures++; $display("FAIL midrst_refetch got=%b/%h exp=10/%h", acks, d, mem_byte(flash_addr(0, b))); end
      checks++; if (g_env[0].cmd_last !== 8'hEB) begin failures++; $display("FAIL midrst_cmd got=%h exp=eb", g_env[0].cmd_last); end
      @(negedge clk);
   endtask

   task automatic test_wrap_dummy8();
      int cyc; logic [1:0] acks; logic [7:0] d;
      r0a[1] = 12'hFFF;
      r0v[1] = 1'b1;
      wait_ack(1, 120, cyc, acks, d);
      r0v[1] = 1'b0;
      checks++; if (cyc + 1 !== 54) begin failures++; $display("FAIL wrap_latency got=%0d exp=54", cyc + 1); end
      checks++; if (g_env[1].fa_last !== flash_addr(1, 12'hFFF)) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", g_env[1].fa_last, flash_addr(1, 12'hFFF)); end
      checks++; if (acks !== 2'b01 || d !== mem_byte(flash_addr(1, 12'hFFF))) begin failures++; $display("FAIL wrap_rdata got=%b/%h exp=01/%h", acks, d, mem_byte(flash_addr(1, 12'hFFF))); end
      checks++; if (g_env[1].last_nsck !== 18 + dummy_of(1)) begin failures++; $display("FAIL wrap_sck_count got=%0d exp=%0d", g_env[1].last_nsck, 18 + dummy_of(1)); end
      @(negedge clk);
   endtask

   task automatic test_protocol();
      checks++; if (g_env[0].proto_err !== 0) begin failures++; $display("FAIL proto_oe_env0 got=%0d exp=0", g_env[0].proto_err); end
      checks++; if (g_env[1].proto_err !== 0) begin failures++; $display("FAIL proto_oe_env1 got=%0d exp=0", g_env[1].proto_err); end
      checks++; if (g_env[0].idle_err !== 0)  begin failures++; $display("FAIL idle_bus_env0 got=%0d exp=0", g_env[0].idle_err); end
      checks++; if (g_env[1].idle_err !== 0)  begin failures++; $display("FAIL idle_bus_env1 got=%0d exp=0", g_env[1].idle_err); end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_random_fetch();
      test_back_to_back();
      test_late_change();
      test_reset_mid();
      test_wrap_dummy8();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
